slave_wishbone: RTL

Wishbone B3/B4 classic and registered-feedback burst responder backed by a local word memory. It is the target end of the single-slave link: it answers the cycles issued by the single-slave master (address/data/select/strobe/cycle/CTI/tag) with registered `ack_o` or `err_o`, read data, and a state indication. It supports the following:
- Classic single cycles, with one wait state.
- Constant-address bursts (CTI 001) and incrementing bursts (CTI 010), with zero-wait beats after the first.
- Error termination for illegal addresses.

---
 rtl/slave_wishbone_if.sv | 30 +++
 rtl/slave_wishbone.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/slave_wishbone_if.sv
// rtl/slave_wishbone_if.sv - Wishbone single-slave link signal bundle
interface slave_wishbone_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = DATA_WIDTH / 8
);
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [DATA_WIDTH-1:0] data_i;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  we_i;
  logic [SEL_WIDTH-1:0]  sel_i;
  logic                  stb_i;
  logic                  cyc_i;
  logic [2:0]            cti_i;
  logic                  tag_add_i;
  logic                  tag_o;
  logic                  ack_o;
  logic                  err_o;
  logic [1:0]            state_out;

  modport master (
    output addr_i, data_i, we_i, sel_i, stb_i, cyc_i, cti_i, tag_add_i,
    input  data_o, tag_o, ack_o, err_o, state_out
  );

  modport slave (
    input  addr_i, data_i, we_i, sel_i, stb_i, cyc_i, cti_i, tag_add_i,
    output data_o, tag_o, ack_o, err_o, state_out
  );
endinterface

// File: rtl/slave_wishbone.sv
// rtl/slave_wishbone.sv - Wishbone classic/registered-feedback burst slave over a local word memory
module slave_wishbone #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    SEL_WIDTH  = DATA_WIDTH / 8,
  parameter int                    MEM_DEPTH  = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input logic             clk_i,
  input logic             rst_i,
  slave_wishbone_if.slave wb
);

  localparam int LSB   = $clog2(SEL_WIDTH);
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(SEL_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A    = ADDR_WIDTH'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(SEL_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RESPOND = 2'b01,
    ST_BURST   = 2'b10
  } state_t;

  state_t                state_q, state_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic                  tag_q, tag_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                  req;
  logic                  term;
  logic                  commit;
  logic                  burst_cti;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [IDX_W-1:0]      cur_idx;

  function automatic logic addr_legal(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && ((a & ALIGN_MASK) == '0) && ((off >> LSB) < DEPTH_A);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> LSB);
  endfunction

  assign req       = wb.cyc_i & wb.stb_i;
  assign term      = (ack_q | err_q) & req;
  assign commit    = term & ack_q & wb.we_i;
  assign burst_cti = (wb.cti_i == 3'b001) || (wb.cti_i == 3'b010);
  // Registered feedback: an incrementing continuation prefetches the word after the current beat.
  assign next_addr = (wb.cti_i == 3'b010) ? wb.addr_i + STEP : wb.addr_i;
  assign cur_idx   = word_idx(wb.addr_i);

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    err_d   = err_q;
    tag_d   = tag_q;
    data_d  = data_q;

    if (term) begin
      tag_d = wb.tag_add_i;
    end

    if (!wb.cyc_i) begin
      state_d = ST_IDLE;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      data_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (req) begin
            if (addr_legal(wb.addr_i)) begin
              ack_d   = 1'b1;
              data_d  = mem[cur_idx];
              state_d = burst_cti ? ST_BURST : ST_RESPOND;
            end else begin
              err_d   = 1'b1;
              state_d = ST_RESPOND;
            end
          end
        end
        ST_RESPOND: begin
          if (term) begin
            ack_d   = 1'b0;
            err_d   = 1'b0;
            data_d  = '0;
            state_d = ST_IDLE;
          end
        end
        ST_BURST: begin
          if (term) begin
            if (burst_cti && addr_legal(next_addr)) begin
              ack_d  = 1'b1;
              data_d = mem[word_idx(next_addr)];
            end else if (burst_cti) begin
              ack_d   = 1'b0;
              err_d   = 1'b1;
              data_d  = '0;
              state_d = ST_RESPOND;
            end else begin
              ack_d   = 1'b0;
              data_d  = '0;
              state_d = ST_IDLE;
            end
          end
        end
        default: begin
          ack_d   = 1'b0;
          err_d   = 1'b0;
          data_d  = '0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      tag_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (commit) begin
      for (int n = 0; n < SEL_WIDTH; n++) begin
        if (wb.sel_i[n]) begin
          mem[cur_idx][8*n +: 8] <= wb.data_i[8*n +: 8];
        end
      end
    end
  end

  assign wb.ack_o     = ack_q;
  assign wb.err_o     = err_q;
  assign wb.tag_o     = tag_q;
  assign wb.data_o    = data_q;
  assign wb.state_out = state_q;

endmodule
